// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage DeltaRV pipeline.
// It handles load-use stalls, data-memory wait freezes and redirect squashes with refill bubbles.
// Outputs are combinational from the registered state and the current inputs. The state updates on the posedge of clk.
//
// Ports:
//   clk, rst            : clock; synchronous active-high reset
//   ID_rs1/ID_rs2       : source registers of the instruction in ID
//   ID_ValidReg         : [0] rd written, [1] rs1 read, [2] rs2 read
//   EX_rd/EX_ValidReg   : destination register and validity of the instruction in EX
//   EX_MemRead          : the instruction in EX is a load
//   EX_redirect         : a taken branch or jump resolved in EX
//   MEM_req/MEM_ack     : data-memory request from MEM / completion this cycle
//   PC_en ... MEM_WB_flush : per-stage enable and flush controls
//   mem_timeout         : sticky flag, set when a memory wait reaches MEM_TIMEOUT cycles
//
// Optional build macro HAZARD_PERF_EN adds two outputs, stall_cycles[31:0] and flush_events[31:0].
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic [2:0] ID_ValidReg,
    input  logic [4:0] EX_rd,
    input  logic [2:0] EX_ValidReg,
    input  logic       EX_MemRead,
    input  logic       EX_redirect,
    input  logic       MEM_req,
    input  logic       MEM_ack,
    output logic       PC_en,
    output logic       IF_ID_en,
    output logic       IF_ID_flush,
    output logic       ID_EX_en,
    output logic       ID_EX_flush,
    output logic       EX_MEM_en,
    output logic       MEM_WB_flush,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, REFILL} state_t;

    localparam logic [2:0]  RB   = 3'(REDIRECT_BUBBLES);
    localparam logic [15:0] WMAX = 16'(MEM_TIMEOUT);

    state_t      state, state_nxt;
    logic [2:0]  bub_cnt, bub_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        tmo_q, tmo_nxt;
    logic        luh, mst;

    assign luh = EX_MemRead & EX_ValidReg[0] & (EX_rd != 5'd0) &
                 ((ID_ValidReg[1] & (ID_rs1 == EX_rd)) |
                  (ID_ValidReg[2] & (ID_rs2 == EX_rd)));
    assign mst = MEM_req & ~MEM_ack;

    // The flag is forced low during reset as well as being cleared by it.
    assign mem_timeout = tmo_q & ~rst;

    always_comb begin
        PC_en        = 1'b1;
        IF_ID_en     = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_en     = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_en    = 1'b1;
        MEM_WB_flush = 1'b0;
        state_nxt    = state;
        bub_nxt      = bub_cnt;
        wait_nxt     = wait_cnt;
        tmo_nxt      = tmo_q;

        if (rst) begin
            PC_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_en     = 1'b0;
            EX_MEM_en    = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if ((state != MEM_WAIT && mst) || (state == MEM_WAIT && !MEM_ack)) begin
            // Freeze everything upstream of MEM and bubble into WB.
            PC_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_en     = 1'b0;
            EX_MEM_en    = 1'b0;
            MEM_WB_flush = 1'b1;
            state_nxt    = MEM_WAIT;
            if (state != MEM_WAIT) begin
                // Entering a wait abandons any refill that is left, because those slots are already bubbles.
                wait_nxt = 16'd1;
                if (WMAX == 16'd1) tmo_nxt = 1'b1;
            end else if (wait_cnt < WMAX) begin
                wait_nxt = wait_cnt + 16'd1;
                if (wait_cnt + 16'd1 == WMAX) tmo_nxt = 1'b1;
            end
        end else if (EX_redirect) begin
            // A redirect squashes ID, so it also masks any load-use hazard.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
                state_nxt = REFILL;
                bub_nxt   = RB;
            end else begin
                state_nxt = RUN;
            end
        end else if (state == REFILL) begin
            // ID holds a bubble during the refill, so load-use detection does not apply here.
            IF_ID_flush = 1'b1;
            bub_nxt     = bub_cnt - 3'd1;
            if (bub_cnt <= 3'd1) state_nxt = RUN;
        end else begin
            // RUN, or the MEM_ack cycle of MEM_WAIT.
            state_nxt = RUN;
            if (luh) begin
                PC_en       = 1'b0;
                IF_ID_en    = 1'b0;
                ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            bub_cnt  <= 3'd0;
            wait_cnt <= 16'd0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            bub_cnt  <= bub_nxt;
            wait_cnt <= wait_nxt;
            tmo_q    <= tmo_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    // IF_ID_flush and ID_EX_flush are high together outside reset only when a redirect is taken.
    logic redir_flush;
    assign redir_flush = ~rst & IF_ID_flush & ID_EX_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (!PC_en)      stall_cycles <= stall_cycles + 32'd1;
            if (redir_flush) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REDIRECT_BUBBLES=2, MEM_TIMEOUT=4).
// A vector table covers single-cycle decisions from RUN; hand sequences cover multi-cycle behaviour.
// Outputs are packed as {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush, mem_timeout}.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic [2:0] ID_ValidReg, EX_ValidReg;
    logic       EX_MemRead, EX_redirect, MEM_req, MEM_ack;
    logic       PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush, mem_timeout;
    logic [7:0] obs;

    assign obs = {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush, mem_timeout};

    pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg),
        .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead),
        .EX_redirect(EX_redirect), .MEM_req(MEM_req), .MEM_ack(MEM_ack),
        .PC_en(PC_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
        .ID_EX_en(ID_EX_en), .ID_EX_flush(ID_EX_flush), .EX_MEM_en(EX_MEM_en),
        .MEM_WB_flush(MEM_WB_flush), .mem_timeout(mem_timeout)
    );

    localparam logic [7:0] NORM = 8'b1101_0100;
    localparam logic [7:0] RSTV = 8'b0010_1010;
    localparam logic [7:0] FRZ  = 8'b0000_0010;
    localparam logic [7:0] LUH  = 8'b0001_1100;
    localparam logic [7:0] RDR  = 8'b1111_1100;
    localparam logic [7:0] RFL  = 8'b1111_0100;
    localparam logic [7:0] TMO  = 8'b0000_0001;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] idvr;
        logic [4:0] exrd;
        logic [2:0] exvr;
        logic       mr;
        logic       redir;
        logic       mreq;
        logic       mack;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[14];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(string nm, logic [4:0] rs1, logic [4:0] rs2, logic [2:0] idvr,
                                logic [4:0] exrd, logic [2:0] exvr, logic mr, logic redir,
                                logic mreq, logic mack, logic [7:0] exp);
        vec_t v;
        v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.idvr = idvr; v.exrd = exrd; v.exvr = exvr;
        v.mr = mr; v.redir = redir; v.mreq = mreq; v.mack = mack; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_ValidReg = v.idvr;
        EX_rd = v.exrd; EX_ValidReg = v.exvr; EX_MemRead = v.mr;
        EX_redirect = v.redir; MEM_req = v.mreq; MEM_ack = v.mack;
    endtask

    // The load-use pair is lw x5 in EX and add rs1=x5 in ID.
    task automatic set_in(input logic luh_on, input logic redir, input logic mreq, input logic mack);
        ID_rs1 = 5'd5; ID_rs2 = 5'd0; ID_ValidReg = luh_on ? 3'b011 : 3'b000;
        EX_rd = 5'd5; EX_ValidReg = luh_on ? 3'b001 : 3'b000; EX_MemRead = luh_on;
        EX_redirect = redir; MEM_req = mreq; MEM_ack = mack;
    endtask

    // Sample on the falling edge, then move to just after the next rising edge to drive.
    task automatic cyc_chk(input string nm, input logic [7:0] exp);
        @(negedge clk);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("reset", RSTV);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk("luh_rs1",        5'd5, 5'd0, 3'b011, 5'd5, 3'b001, 1, 0, 0, 0, LUH);
        tbl[1]  = mk("luh_rs2",        5'd1, 5'd7, 3'b101, 5'd7, 3'b001, 1, 0, 0, 0, LUH);
        tbl[2]  = mk("x0_no_stall",    5'd0, 5'd0, 3'b111, 5'd0, 3'b001, 1, 0, 0, 0, NORM);
        tbl[3]  = mk("rs2_unused",     5'd3, 5'd7, 3'b011, 5'd7, 3'b001, 1, 0, 0, 0, NORM);
        tbl[4]  = mk("not_load",       5'd5, 5'd0, 3'b011, 5'd5, 3'b001, 0, 0, 0, 0, NORM);
        tbl[5]  = mk("ex_no_rd",       5'd5, 5'd0, 3'b011, 5'd5, 3'b000, 1, 0, 0, 0, NORM);
        tbl[6]  = mk("rs1_unused",     5'd5, 5'd0, 3'b001, 5'd5, 3'b001, 1, 0, 0, 0, NORM);
        tbl[7]  = mk("redir_masks",    5'd5, 5'd0, 3'b011, 5'd5, 3'b001, 1, 1, 0, 0, RDR);
        tbl[8]  = mk("mst",            5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 0, 0, 1, 0, FRZ);
        tbl[9]  = mk("mst_over_redir", 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 0, 1, 1, 0, FRZ);
        tbl[10] = mk("req_acked",      5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 0, 0, 1, 1, NORM);
        tbl[11] = mk("acked_luh",      5'd5, 5'd0, 3'b011, 5'd5, 3'b001, 1, 0, 1, 1, LUH);
        tbl[12] = mk("idle",           5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 0, 0, 0, 0, NORM);
        tbl[13] = mk("ack_no_req",     5'd9, 5'd9, 3'b111, 5'd9, 3'b001, 0, 0, 0, 1, NORM);

        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();
        cyc_chk("after_reset", NORM);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            apply(tbl[i]);
            cyc_chk(tbl[i].name, tbl[i].exp);
        end

        // Load-use: a single stall cycle, then the load has moved on.
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_chk("lu_stall", LUH);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("lu_release", NORM);

        // Memory wait of three cycles, then ack. Afterwards the state is RUN, so load-use stalls again.
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        cyc_chk("mw_1", FRZ);
        cyc_chk("mw_2", FRZ);
        cyc_chk("mw_3", FRZ);
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        cyc_chk("mw_ack", NORM);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_chk("mw_back_run", LUH);

        // Redirect with two refill bubbles.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc_chk("rd_0", RDR);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("rd_1", RFL);
        cyc_chk("rd_2", RFL);
        cyc_chk("rd_done", NORM);

        // A redirect during refill reloads the bubble count.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc_chk("rl_0", RDR);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("rl_1", RFL);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc_chk("rl_again", RDR);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("rl_2", RFL);
        cyc_chk("rl_3", RFL);
        cyc_chk("rl_done", NORM);

        // A memory stall during refill abandons the remaining bubbles.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc_chk("rm_0", RDR);
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        cyc_chk("rm_frz1", FRZ);
        cyc_chk("rm_frz2", FRZ);
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        cyc_chk("rm_ack", NORM);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("rm_no_refill", NORM);

        // mst together with a redirect: the pipeline freezes first, and the flush is issued in the ack cycle.
        set_in(1'b0, 1'b1, 1'b1, 1'b0);
        cyc_chk("mr_frz1", FRZ);
        cyc_chk("mr_frz2", FRZ);
        set_in(1'b0, 1'b1, 1'b1, 1'b1);
        cyc_chk("mr_ack_flush", RDR);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("mr_refill1", RFL);
        cyc_chk("mr_refill2", RFL);
        cyc_chk("mr_done", NORM);

        // Load-use that is resolved in the ack cycle.
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        cyc_chk("ml_frz", FRZ);
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        cyc_chk("ml_ack_luh", LUH);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("ml_done", NORM);

        // Timeout with MEM_TIMEOUT=4. The first frozen cycle is in RUN, so the 4th cycle spent in MEM_WAIT is frozen cycle 5.
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        cyc_chk("to_1", FRZ);
        cyc_chk("to_2", FRZ);
        cyc_chk("to_3", FRZ);
        cyc_chk("to_4", FRZ);
        cyc_chk("to_5", FRZ | TMO);
        cyc_chk("to_6", FRZ | TMO);
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        cyc_chk("to_ack", NORM | TMO);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("to_sticky", NORM | TMO);

        // Reset in the middle of a wait.
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        cyc_chk("rw_1", FRZ | TMO);
        cyc_chk("rw_2", FRZ | TMO);
        rst = 1'b1;
        cyc_chk("rw_rst", RSTV);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_chk("rw_cleared", NORM);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_chk("rw_run", LUH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
